// File: rtl/logic_unit_arbiter_if.sv
// Bundle between the requesters, the shared bitwise logic unit and the result consumer.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
interface logic_unit_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [2*N_REQ-1:0]     req_op;
    logic [WIDTH*N_REQ-1:0] req_a;
    logic [WIDTH*N_REQ-1:0] req_b;
    logic [WIDTH-1:0]       lu_a;
    logic [WIDTH-1:0]       lu_b;
    logic [1:0]             lu_op;
    logic [WIDTH-1:0]       lu_s;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_data;

    modport slave (
        input  req_valid, req_op, req_a, req_b, lu_s, rsp_ready,
        output req_ready, lu_a, lu_b, lu_op, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_op, req_a, req_b, lu_s, rsp_ready,
        input  req_ready, lu_a, lu_b, lu_op, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one combinational bitwise logic unit among N_REQ requesters;
// one operation in flight, operands and result registered.
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    logic_unit_arbiter_if.slave  bus,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  gid_q, gid_d;
    logic [WIDTH-1:0] lu_a_q, lu_a_d;
    logic [WIDTH-1:0] lu_b_q, lu_b_d;
    logic [1:0]       lu_op_q, lu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W:0]    cand;
    logic [N_REQ-1:0] req_ready_c;

    // Search starts one past the last granted requester, wrapping modulo N_REQ.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
            if (!grant_valid && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        lu_a_d      = lu_a_q;
        lu_b_d      = lu_b_q;
        lu_op_d     = lu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    req_ready_c[grant_idx] = 1'b1;
                    lu_a_d  = bus.req_a[WIDTH*grant_idx +: WIDTH];
                    lu_b_d  = bus.req_b[WIDTH*grant_idx +: WIDTH];
                    lu_op_d = bus.req_op[2*grant_idx +: 2];
                    gid_d   = grant_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = bus.lu_s;
                rsp_id_d    = gid_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = gid_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(N_REQ - 1);
            gid_q       <= '0;
            lu_a_q      <= '0;
            lu_b_q      <= '0;
            lu_op_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gid_q       <= gid_d;
            lu_a_q      <= lu_a_d;
            lu_b_q      <= lu_b_d;
            lu_op_q     <= lu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // No accept pulse may escape while reset is held, even though IDLE is combinational.
    assign bus.req_ready = rst_ni ? req_ready_c : '0;
    assign bus.lu_a      = lu_a_q;
    assign bus.lu_b      = lu_b_q;
    assign bus.lu_op     = lu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a behavioural shared logic unit.
module tb_logic_unit_arbiter;
    localparam int N_REQ = 4;
    localparam int WIDTH = 32;
    localparam int ID_W  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] state;
    int         checks = 0;
    int         errors = 0;

    logic [1:0]  rr_ids  [5];
    logic [31:0] rr_data [4];

    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

    logic_unit_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bus     (bus.slave),
        .state_o (state)
    );

    // Shared unit: 00 AND, 01 OR, 10 XOR, 11 NOR
    always_comb begin
        case (bus.lu_op)
            2'b00:   bus.lu_s = bus.lu_a & bus.lu_b;
            2'b01:   bus.lu_s = bus.lu_a | bus.lu_b;
            2'b10:   bus.lu_s = bus.lu_a ^ bus.lu_b;
            default: bus.lu_s = ~(bus.lu_a | bus.lu_b);
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[2*i +: 2]         = op;
        bus.req_a[WIDTH*i +: WIDTH]  = a;
        bus.req_b[WIDTH*i +: WIDTH]  = b;
    endtask

    task automatic init_reqs();
        set_req(0, 2'b01, 32'h1234_5678, 32'h0F0F_0F0F);
        set_req(1, 2'b10, 32'hFFFF_0000, 32'h0F0F_0F0F);
        set_req(2, 2'b11, 32'hF0F0_F0F0, 32'h0F0F_0000);
        set_req(3, 2'b00, 32'hAAAA_AAAA, 32'hFFFF_0000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        init_reqs();
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
            checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
            checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
            checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
            checks++; if ({bus.lu_a, bus.lu_b, bus.lu_op} !== '0) begin errors++; $display("FAIL reset_lu: got %h %h %b expected zeros", bus.lu_a, bus.lu_b, bus.lu_op); end
        end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.lu_a !== 32'h1234_5678 || bus.lu_b !== 32'h0F0F_0F0F || bus.lu_op !== 2'b01) begin errors++; $display("FAIL reset_lu_issue: got %h %h %b expected 12345678 0f0f0f0f 01", bus.lu_a, bus.lu_b, bus.lu_op); end
        checks++; if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_exec: got ready %b valid %b expected 0000 0", bus.req_ready, bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 32'h1F3F_5F7F) begin errors++; $display("FAIL reset_first_rsp: got %b %0d %h expected 1 0 1f3f5f7f", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_drop: got %b expected 0", bus.rsp_valid); end
    endtask

    task automatic test_single();
        set_req(2, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00);
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_exec: got ready %b valid %b expected 0000 0", bus.req_ready, bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== 32'hF000_F000) begin errors++; $display("FAIL single_rsp: got %b %0d %h expected 1 2 f000f000", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.lu_a !== 32'hF0F0_F0F0 || bus.lu_op !== 2'b00) begin errors++; $display("FAIL single_idle_hold: got %b %h %b expected 0 f0f0f0f0 00", bus.rsp_valid, bus.lu_a, bus.lu_op); end
    endtask

    task automatic test_round_robin();
        rr_ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_data = '{32'h1F3F_5F7F, 32'hF0F0_0F0F, 32'h0000_0F0F, 32'hAAAA_0000};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        init_reqs();
        bus.req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            checks++; if (bus.req_ready !== (4'b0001 << rr_ids[n])) begin errors++; $display("FAIL rr_grant%0d: got %b expected id %0d", n, bus.req_ready, rr_ids[n]); end
            tick();
            checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rr_exec%0d: got valid %b ready %b expected 0 0000", n, bus.rsp_valid, bus.req_ready); end
            tick();
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== rr_ids[n] || bus.rsp_data !== rr_data[rr_ids[n]]) begin errors++; $display("FAIL rr_rsp%0d: got %b %0d %h expected 1 %0d %h", n, bus.rsp_valid, bus.rsp_id, bus.rsp_data, rr_ids[n], rr_data[rr_ids[n]]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b expected 0010", bus.req_ready); end
        tick();
        bus.rsp_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 32'hF0F0_0F0F) begin errors++; $display("FAIL bp_hold%0d: got %b %0d %h expected 1 1 f0f00f0f", c, bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0000", c, bus.req_ready); end
            if (c < 4) tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release: got valid %b ready %b expected 0 0100", bus.rsp_valid, bus.req_ready); end
        tick();
        checks++; if (bus.lu_a !== 32'hF0F0_F0F0 || bus.lu_b !== 32'h0F0F_0000 || bus.lu_op !== 2'b11) begin errors++; $display("FAIL bp_next_issue: got %h %h %b expected f0f0f0f0 0f0f0000 11", bus.lu_a, bus.lu_b, bus.lu_op); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== 32'h0000_0F0F) begin errors++; $display("FAIL bp_next_rsp: got %b %0d %h expected 1 2 00000f0f", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant: got %b expected 0010", bus.req_ready); end
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL mid_in_exec: got state %0d expected 1", state); end
        rst_n = 1'b0;
        bus.req_valid = 4'b0011;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_in_reset: got %b expected 0000", bus.req_ready); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 32'h0) begin errors++; $display("FAIL mid_rsp_cleared: got %b %0d %h expected 0 0 0", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        checks++; if (bus.lu_a !== 32'h0 || bus.lu_b !== 32'h0 || bus.lu_op !== 2'b00 || state !== 2'd0) begin errors++; $display("FAIL mid_lu_cleared: got %h %h %b state %0d expected zeros idle", bus.lu_a, bus.lu_b, bus.lu_op, state); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant_order: got %b expected 0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0010;
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 32'h1F3F_5F7F) begin errors++; $display("FAIL mid_req0_rsp: got %b %0d %h expected 1 0 1f3f5f7f", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        tick();
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_req1_regrant: got %b expected 0010", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 32'hF0F0_0F0F) begin errors++; $display("FAIL mid_req1_rsp: got %b %0d %h expected 1 1 f0f00f0f", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
